// File: rtl/keypad_pkg.sv
// Shared widths, types and the lowest-set-bit priority helper for the keypad
// key encoder.
package keypad_pkg;

    localparam int KEY_W  = 16;
    localparam int CODE_W = 4;

    typedef logic [KEY_W-1:0]  key_vec_t;
    typedef logic [CODE_W-1:0] key_code_t;

    typedef struct packed {
        logic      found;
        key_code_t code;
    } lowest_t;

    // Scanning from the top down lets the lowest set bit win last.
    function automatic lowest_t lowest_set(input key_vec_t vec);
        lowest_t result;
        result.found = 1'b0;
        result.code  = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                result.found = 1'b1;
                result.code  = key_code_t'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head output; a push is accepted while
// full provided a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_next = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    // The next head is the word being written when it lands exactly where the
    // read pointer is heading, otherwise whatever is already stored there.
    assign head_next = (do_push && (wr_ptr == rd_next)) ? push_data : mem[rd_next];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            rd_ptr <= rd_next;
            head_q <= head_next;
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data = head_q;
    assign count    = count_q;

endmodule

// File: rtl/keypad_key_encoder.sv
// Turns debounced key-state edges into a queue of 4-bit key codes, lowest key
// first, delivered over a valid/ready handshake.
module keypad_key_encoder
    import keypad_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  key_vec_t                      keys,
    output key_code_t                     key_code,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    key_vec_t  keys_prev;
    key_vec_t  pending;
    key_vec_t  new_press;
    key_vec_t  grant_onehot;
    lowest_t   lowest;
    logic      fifo_full;
    logic      fifo_empty;
    logic      pop;
    logic      can_accept;
    logic      grant;
    logic      duplicate;

    assign new_press = keys & ~keys_prev;
    assign lowest    = lowest_set(pending);
    assign pop       = key_valid && key_ready;
    assign can_accept = !fifo_full || pop;
    assign grant     = lowest.found && can_accept;

    always_comb begin
        grant_onehot = '0;
        if (grant) begin
            grant_onehot = key_vec_t'(1) << lowest.code;
        end
    end

    // A press on a key whose earlier press is still waiting collapses into it.
    assign duplicate = |(new_press & pending & ~grant_onehot);

    // keys_prev resets to all-ones so keys held across reset never register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keys_prev <= '1;
            pending   <= '0;
        end else begin
            keys_prev <= keys;
            pending   <= (pending & ~grant_onehot) | new_press;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (duplicate) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (lowest.code),
        .pop       (pop),
        .pop_data  (key_code),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign key_valid = !fifo_empty;

endmodule

// File: tb/tb_keypad_key_encoder.sv
// Directed and randomized checks of keypad_key_encoder against a queue-based
// model of press arbitration and delivery.
module tb_keypad_key_encoder;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   keys = 16'h0001;
    logic          key_ready = 1'b0;
    logic          clr_overflow = 1'b0;
    logic [3:0]    key_code;
    logic          key_valid;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    int checks = 0;
    int errors = 0;

    int          mq[$];
    bit          mpend[16];
    logic [15:0] mprev;
    bit          movf;
    logic [15:0] rkeys;

    always #5 clk = ~clk;

    keypad_key_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .keys         (keys),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .fifo_count   (fifo_count)
    );

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 16; i++) mpend[i] = 1'b0;
        mprev = 16'hFFFF;
        movf  = 1'b0;
    endtask

    // One clock of the model: deliver, then take the lowest waiting key if
    // there is room, then record fresh presses.
    task automatic model_update();
        bit popped;
        bit dup;
        int low;
        int tmp;
        popped = (mq.size() != 0) && key_ready;
        low = -1;
        for (int i = 15; i >= 0; i--) if (mpend[i]) low = i;
        if (popped) tmp = mq.pop_front();
        if (low >= 0 && mq.size() < DEPTH) begin
            mq.push_back(low);
            mpend[low] = 1'b0;
        end
        dup = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (keys[i] && !mprev[i]) begin
                if (mpend[i]) dup = 1'b1;
                mpend[i] = 1'b1;
            end
        end
        if (dup) movf = 1'b1;
        else if (clr_overflow) movf = 1'b0;
        mprev = keys;
    endtask

    task automatic check_output();
        check("key_valid", int'(key_valid), (mq.size() != 0) ? 1 : 0);
        check("fifo_count", int'(fifo_count), mq.size());
        check("overflow", int'(overflow), int'(movf));
        if (mq.size() != 0) check("key_code", int'(key_code), mq[0]);
    endtask

    task automatic apply_stimulus(input logic [15:0] k, input logic r, input logic c);
        @(negedge clk);
        keys         = k;
        key_ready    = r;
        clr_overflow = c;
        @(posedge clk);
        model_update();
        #1;
        check_output();
    endtask

    initial begin
        $display("[TB] start");
        model_reset();

        // Key 0 held across reset must not be reported.
        #2;
        check("reset_valid", int'(key_valid), 0);
        check("reset_count", int'(fifo_count), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_code", int'(key_code), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) apply_stimulus(16'h0001, 1'b0, 1'b0);
        check("held_through_reset", int'(key_valid), 0);
        apply_stimulus(16'h0000, 1'b0, 1'b0);
        apply_stimulus(16'h0001, 1'b0, 1'b0);
        check("latency_not_yet", int'(key_valid), 0);
        apply_stimulus(16'h0001, 1'b0, 1'b0);
        check("latency_valid", int'(key_valid), 1);
        check("latency_code", int'(key_code), 0);
        apply_stimulus(16'h0000, 1'b1, 1'b0);
        apply_stimulus(16'h0000, 1'b1, 1'b0);

        // Single press of key 5 accepted once, nothing repeats while held.
        apply_stimulus(16'h0020, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) apply_stimulus(16'h0020, 1'b1, 1'b0);
        apply_stimulus(16'h0000, 1'b1, 1'b0);
        check("single_drained", int'(fifo_count), 0);

        // Four simultaneous presses queue in ascending order.
        apply_stimulus(16'h8421, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) apply_stimulus(16'h0000, 1'b0, 1'b0);
        check("multi_full", int'(fifo_count), 4);
        check("multi_head", int'(key_code), 0);
        for (int i = 0; i < 4; i++) apply_stimulus(16'h0000, 1'b1, 1'b0);
        check("multi_drained", int'(fifo_count), 0);

        // Full FIFO stalls key 3; one pop lets it in with count unchanged.
        apply_stimulus(16'h0017, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) apply_stimulus(16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) apply_stimulus(16'h0008, 1'b0, 1'b0);
        check("stall_code", int'(key_code), 0);
        apply_stimulus(16'h0008, 1'b1, 1'b0);
        check("swap_count", int'(fifo_count), 4);
        check("swap_head", int'(key_code), 1);
        for (int i = 0; i < 6; i++) apply_stimulus(16'h0000, 1'b1, 1'b0);

        // Re-press of a waiting key 7 raises overflow, one code delivered.
        apply_stimulus(16'h000F, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) apply_stimulus(16'h0000, 1'b0, 1'b0);
        apply_stimulus(16'h0080, 1'b0, 1'b0);
        apply_stimulus(16'h0000, 1'b0, 1'b0);
        apply_stimulus(16'h0080, 1'b0, 1'b0);
        check("dup_overflow", int'(overflow), 1);
        for (int i = 0; i < 8; i++) apply_stimulus(16'h0000, 1'b1, 1'b0);
        check("dup_drained", int'(fifo_count), 0);
        apply_stimulus(16'h0000, 1'b0, 1'b1);
        check("overflow_cleared", int'(overflow), 0);

        // Asynchronous reset with codes queued and keys waiting.
        apply_stimulus(16'h0007, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(16'h0000, 1'b0, 1'b0);
        apply_stimulus(16'h0030, 1'b0, 1'b0);
        check("pre_reset_count", int'(fifo_count), 3);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", int'(key_valid), 0);
        check("async_count", int'(fifo_count), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) apply_stimulus(16'h0030, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) apply_stimulus(16'h0000, 1'b1, 1'b0);
        check("no_stale", int'(fifo_count), 0);

        // Randomized sparse toggling of keys with random backpressure.
        rkeys = 16'h0000;
        for (int i = 0; i < 400; i++) begin
            rkeys = rkeys ^ 16'($urandom & $urandom & $urandom);
            apply_stimulus(rkeys, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_key_encoder.md
Name: keypad_key_encoder

Overview:
- Converts the 16-bit debounced key-state vector from the keypad decoder into a stream of 4-bit key codes, one code per key press.
- A valid/ready handshake delivers the codes to the game controller.
- Sits directly downstream of the decoder: decoder keys[15:0] → this block → guess/compare logic.
- Detects press edges and arbitrates simultaneous presses lowest-index-first. Buffers codes in a small FIFO so that no press is lost while the consumer stalls.

Parameters:
- FIFO_DEPTH, 4, code FIFO entries. Must be a power of two and ≥ 2.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- keys  input  16  debounced key state from the decoder; bit i = 1 means key i is held; synchronous to clk
- key_code  output  4  code at the FIFO head (= bit index of the pressed key)
- key_valid  output  1  FIFO non-empty; key_code is meaningful
- key_ready  input  1  consumer accepts key_code when key_valid && key_ready
- overflow  output  1  sticky; a press was dropped
- clr_overflow  input  1  synchronous clear of overflow
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high. All state is cleared on rst assertion, independent of clk.
- Reset values:
  - key_code = 0, key_valid = 0, overflow = 0, fifo_count = 0
  - pending = 0
  - keys_prev = 16'hFFFF. Keys held through reset release are not reported; they must be released and pressed again.
- Edge detect: new_press = keys & ~keys_prev. keys_prev <= keys every cycle.
- Pending mask (16 bits):
  - pending <= (pending & ~grant_onehot) | new_press.
  - If new_press[i] arrives while pending[i] = 1 and i is not granted in that cycle, the press is a duplicate: overflow <= 1 and pending[i] stays 1. One code is still delivered.
- Grant:
  - Each cycle, if pending != 0 and the FIFO can accept, grant the lowest set bit i. Push code i and clear pending[i].
  - The FIFO can accept when count < FIFO_DEPTH, or when count == FIFO_DEPTH with a pop in the same cycle.
  - Otherwise pending holds unchanged. Nothing is lost except duplicates.
- At most one push per cycle. Higher-index simultaneous presses drain on subsequent cycles in ascending order.
- Latency: keys bit rises before edge N → pending set at edge N → pushed at edge N+1 → key_valid = 1 after edge N+1, with an empty FIFO and no backlog.
- Release of a key after its pending bit is set does not cancel it; the code is still delivered.
- Handshake:
  - key_valid = (count != 0). key_code = FIFO head, registered output.
  - Pop when key_valid && key_ready.
  - key_code and key_valid hold stable while key_valid && !key_ready.
  - key_ready while !key_valid is ignored.
- Simultaneous push and pop: count unchanged; head advances; the new code goes to the tail. With an empty FIFO, a pop and a push cannot coincide.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- overflow:
  - Set on a duplicate press.
  - Cleared by clr_overflow, unless a duplicate occurs in the same cycle; set wins.
- rst asserted mid-operation drops all pending and queued codes immediately.

Decomposition:
- Package keypad_pkg:
  - KEY_W = 16, CODE_W = 4
  - typedef logic [KEY_W-1:0] key_vec_t
  - typedef logic [CODE_W-1:0] key_code_t
  - function lowest_set(key_vec_t) returning key_code_t plus a found flag
- Sub-module sync_fifo, parameterised by width and depth: push/pop/full/empty/count, simultaneous push+pop when full permitted.
- The top level holds keys_prev, pending, the grant logic and overflow.

Test Plan:
- Reset with keys = 16'h0001 held, then release rst and keep key 0 held for 20 cycles → key_valid stays 0. Then release key 0 and press it again → key_code = 0, key_valid = 1 two cycles after the press.
- key_ready = 1, keys 0 → 16'h0020 → 0 → key_code = 5 is accepted once. fifo_count returns to 0 and there is no second code while the key is held.
- key_ready = 0, keys = 16'h8421 in a single cycle → codes 0, 5, 10, 15 are pushed on consecutive cycles and fifo_count = 4. Then key_ready = 1 → pops in the order 0, 5, 10, 15.
- key_ready = 0, FIFO full (4 codes), press key 3 → pending[3] holds and key_valid/key_code stay stable. One pop with key_ready = 1 → code 3 is pushed in the same cycle and fifo_count stays 4.
- FIFO full with key 7 pending, release and re-press key 7 → overflow = 1. Exactly one code 7 is delivered after draining. clr_overflow pulse → overflow = 0.
- Assert rst while 3 codes are queued and 2 are pending → key_valid = 0 and fifo_count = 0 immediately, without waiting for a clk edge. After release, no stale codes appear.
